// File: rtl/msg_validity_checker_if.sv
// Bundles the checker's launch input, RAM read port and result outputs.
// master = checker side, slave = RAM / key-controller side.
interface msg_validity_checker_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [7:0]        q_ram;
    logic [ADDR_W-1:0] address;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W-1:0] fail_index;
    logic [ADDR_W:0]   bad_count;

    modport master (
        input  start,
        input  q_ram,
        output address,
        output busy,
        output done,
        output pass,
        output fail_index,
        output bad_count
    );

    modport slave (
        output start,
        output q_ram,
        input  address,
        input  busy,
        input  done,
        input  pass,
        input  fail_index,
        input  bad_count
    );
endinterface

// File: rtl/msg_validity_checker.sv
// Reads MSG_LEN decrypted bytes and flags non-plaintext; MSG_CHECK_FULL_SCAN_EN scans all bytes and counts bad ones.
// Latency: RD_LAT+1 cycles per byte, done one cycle after the last check (MSG_LEN*(RD_LAT+1)+1 on pass).
// No backpressure: start is edge-launched, result held with done until the next launch.
module msg_validity_checker #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 8,
    parameter int RD_LAT  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    msg_validity_checker_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);
    localparam logic [2:0]        CNT_INIT  = 3'(RD_LAT - 1);
`ifdef MSG_CHECK_FULL_SCAN_EN
    localparam logic [ADDR_W:0]   BAD_MAX   = (ADDR_W + 1)'(MSG_LEN);
`endif

    state_t            state_q, state_d;
    logic              start_q, start_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] fail_index_q, fail_index_d;
    logic [ADDR_W:0]   bad_count_q, bad_count_d;

    logic launch;
    logic byte_ok;

    function automatic logic is_legal(input logic [7:0] b);
        return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
    endfunction

    assign launch  = bus.start & ~start_q;
    assign byte_ok = is_legal(bus.q_ram);

    always_comb begin
        state_d      = state_q;
        start_d      = bus.start;
        cnt_d        = cnt_q;
        address_d    = address_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_index_d = fail_index_q;
        bad_count_d  = bad_count_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                busy_d = 1'b0;
                // done is registered one cycle into DONE so it never overlaps busy
                if (state_q == ST_DONE) begin
                    done_d = 1'b1;
                end
                if (launch) begin
                    address_d    = '0;
                    cnt_d        = CNT_INIT;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    fail_index_d = '0;
                    bad_count_d  = '0;
                    busy_d       = 1'b1;
                    state_d      = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            ST_CHECK: begin
`ifdef MSG_CHECK_FULL_SCAN_EN
                if (!byte_ok) begin
                    if (bad_count_q == '0) begin
                        fail_index_d = address_q;
                    end
                    if (bad_count_q != BAD_MAX) begin
                        bad_count_d = bad_count_q + 1'b1;
                    end
                end
                if (address_q == LAST_ADDR) begin
                    pass_d  = (bad_count_d == '0);
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    address_d = address_q + 1'b1;
                    cnt_d     = CNT_INIT;
                    state_d   = ST_WAIT;
                end
`else
                if (!byte_ok) begin
                    fail_index_d = address_q;
                    bad_count_d  = (ADDR_W + 1)'(1);
                    pass_d       = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = ST_DONE;
                end else if (address_q == LAST_ADDR) begin
                    pass_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    // equality compare above keeps address from wrapping when MSG_LEN == 2**ADDR_W
                    address_d = address_q + 1'b1;
                    cnt_d     = CNT_INIT;
                    state_d   = ST_WAIT;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            cnt_q        <= 3'd0;
            address_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_index_q <= '0;
            bad_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            cnt_q        <= cnt_d;
            address_q    <= address_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_index_q <= fail_index_d;
            bad_count_q  <= bad_count_d;
        end
    end

    assign bus.address    = address_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.fail_index = fail_index_q;
    assign bus.bad_count  = bad_count_q;

endmodule

// File: tb/tb_msg_validity_checker.sv
// Directed bench for msg_validity_checker with a 2-stage registered RAM model.
module tb_msg_validity_checker;

    localparam int MSG_LEN = 32;
    localparam int ADDR_W  = 8;
    localparam int RD_LAT  = 2;
    localparam int PASS_LAT = MSG_LEN * (RD_LAT + 1) + 1;

    logic clk;
    logic reset;

    int n_checks;
    int n_errors;

    logic [7:0] mem [256];
    logic [7:0] ram_p1;
    logic [7:0] ram_p2;

    logic [7:0] bad_vals [3] = '{8'h1F, 8'h60, 8'h7B};
    int         bad_pos  [3] = '{0, 17, 31};

    msg_validity_checker_if #(.ADDR_W(ADDR_W)) bus_if ();

    msg_validity_checker #(
        .MSG_LEN (MSG_LEN),
        .ADDR_W  (ADDR_W),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data for an address appears two edges after it is driven, sampled on the third
    always @(posedge clk) begin
        ram_p1 <= mem[bus_if.address];
        ram_p2 <= ram_p1;
    end
    assign bus_if.q_ram = ram_p2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_all(input logic [7:0] b);
        for (int i = 0; i < 256; i++) mem[i] = b;
    endtask

    task automatic fill_boundary();
        for (int i = 0; i < 256; i++) begin
            case (i % 3)
                0:       mem[i] = 8'h20;
                1:       mem[i] = 8'h61;
                default: mem[i] = 8'h7A;
            endcase
        end
    endtask

    // start low one cycle then high; returns just after the launch-sampling edge
    task automatic launch();
        @(negedge clk) bus_if.start = 1'b0;
        @(negedge clk) bus_if.start = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat, output int busy_cyc, output int max_addr);
        lat      = -1;
        busy_cyc = bus_if.busy ? 1 : 0;
        max_addr = 0;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk);
            #1;
            if (bus_if.busy) begin
                busy_cyc++;
                if (int'(bus_if.address) > max_addr) max_addr = int'(bus_if.address);
            end
            if (bus_if.done) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_address"},    32'(bus_if.address),    32'd0);
        chk({pfx, "_busy"},       32'(bus_if.busy),       32'd0);
        chk({pfx, "_done"},       32'(bus_if.done),       32'd0);
        chk({pfx, "_pass"},       32'(bus_if.pass),       32'd0);
        chk({pfx, "_fail_index"}, 32'(bus_if.fail_index), 32'd0);
        chk({pfx, "_bad_count"},  32'(bus_if.bad_count),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, busy_cyc, max_addr, unstable, exp_lat;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus_if.start = 1'b0;
        fill_all(8'h61);

        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("rst");
        @(negedge clk) reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", 32'(bus_if.busy), 32'd0);

        // all 'a'
        launch();
        chk("a_launch_busy", 32'(bus_if.busy), 32'd1);
        wait_done(lat, busy_cyc, max_addr);
        chk("a_latency",    32'(lat),               32'(PASS_LAT));
        chk("a_busy_cyc",   32'(busy_cyc),          32'd96);
        chk("a_pass",       32'(bus_if.pass),       32'd1);
        chk("a_fail_index", 32'(bus_if.fail_index), 32'd0);
        chk("a_bad_count",  32'(bus_if.bad_count),  32'd0);
        chk("a_address",    32'(bus_if.address),    32'd31);

        // uppercase at 5, '{' at 9 and 31
        fill_all(8'h61);
        mem[5]  = 8'h41;
        mem[9]  = 8'h7B;
        mem[31] = 8'h7B;
        launch();
        wait_done(lat, busy_cyc, max_addr);
        chk("bad5_pass",       32'(bus_if.pass),       32'd0);
        chk("bad5_fail_index", 32'(bus_if.fail_index), 32'd5);
`ifdef MSG_CHECK_FULL_SCAN_EN
        chk("bad5_latency",    32'(lat),               32'(PASS_LAT));
        chk("bad5_bad_count",  32'(bus_if.bad_count),  32'd3);
        chk("bad5_max_addr",   32'(max_addr),          32'd31);
`else
        chk("bad5_latency",    32'(lat),               32'd19);
        chk("bad5_busy_cyc",   32'(busy_cyc),          32'd18);
        chk("bad5_bad_count",  32'(bus_if.bad_count),  32'd1);
        chk("bad5_max_addr",   32'(max_addr),          32'd5);
        chk("bad5_address",    32'(bus_if.address),    32'd5);
`endif

        // boundary legal values
        fill_boundary();
        launch();
        wait_done(lat, busy_cyc, max_addr);
        chk("bnd_latency", 32'(lat),         32'(PASS_LAT));
        chk("bnd_pass",    32'(bus_if.pass), 32'd1);

        // single illegal neighbours of the legal ranges
        for (int t = 0; t < 3; t++) begin
            fill_boundary();
            mem[bad_pos[t]] = bad_vals[t];
`ifdef MSG_CHECK_FULL_SCAN_EN
            exp_lat = PASS_LAT;
`else
            exp_lat = (bad_pos[t] + 1) * (RD_LAT + 1) + 1;
`endif
            launch();
            wait_done(lat, busy_cyc, max_addr);
            chk($sformatf("edge%0d_pass", t),       32'(bus_if.pass),       32'd0);
            chk($sformatf("edge%0d_fail_index", t), 32'(bus_if.fail_index), 32'(bad_pos[t]));
            chk($sformatf("edge%0d_bad_count", t),  32'(bus_if.bad_count),  32'd1);
            chk($sformatf("edge%0d_latency", t),    32'(lat),               32'(exp_lat));
        end

        // start held high after done must not relaunch
        fill_all(8'h61);
        launch();
        wait_done(lat, busy_cyc, max_addr);
        unstable = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (bus_if.busy || !bus_if.done || !bus_if.pass || bus_if.address != 8'd31) unstable++;
        end
        chk("hold_unstable", 32'(unstable), 32'd0);
        launch();
        chk("relaunch_done",    32'(bus_if.done),    32'd0);
        chk("relaunch_busy",    32'(bus_if.busy),    32'd1);
        chk("relaunch_address", 32'(bus_if.address), 32'd0);
        wait_done(lat, busy_cyc, max_addr);
        chk("relaunch_latency", 32'(lat), 32'(PASS_LAT));

        // reset mid-check, released with start still high
        launch();
        repeat (40) @(posedge clk);
        #1;
        chk("mid_address_nonzero", 32'(bus_if.address != 8'd0), 32'd1);
        reset = 1'b1;
        #1;
        chk_outputs_zero("midrst");
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_busy",    32'(bus_if.busy),    32'd1);
        chk("rel_address", 32'(bus_if.address), 32'd0);
        wait_done(lat, busy_cyc, max_addr);
        chk("rel_latency", 32'(lat),         32'(PASS_LAT));
        chk("rel_pass",    32'(bus_if.pass), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/msg_validity_checker.md
Name: msg_validity_checker

Overview:
- Downstream of the RC4 decrypt stage.
- On a rising edge of `start`, it reads MSG_LEN decrypted bytes back from the decrypted-message RAM and classifies the message as plaintext or garbage.
- Plaintext means every byte is lowercase `a`–`z` or space.
- Its pass/fail result and failure position feed the brute-force key controller, which decides whether to advance the key.

Parameters:
- `MSG_LEN`, 32, number of bytes checked (addresses 0..MSG_LEN-1); legal range 1..2^ADDR_W.
- `ADDR_W`, 8, RAM address width.
- `RD_LAT`, 2, wait cycles between driving `address` and sampling `q_ram`; legal range 1..7.

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain).
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level input from decrypt `finish`; its 0->1 transition launches a check.
- `q_ram`  in  8  read data from the decrypted-message RAM.
- `address`  out  ADDR_W  read address to the decrypted-message RAM.
- `busy`  out  1  high while a check is in progress.
- `done`  out  1  high once a check completes; held until the next launch.
- `pass`  out  1  valid when `done`=1; 1 means all checked bytes are legal.
- `fail_index`  out  ADDR_W  address of the first illegal byte; 0 on pass.
- `bad_count`  out  ADDR_W+1  count of illegal bytes (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - `address`, `busy`, `done`, `pass`, `fail_index`, `bad_count` = 0.
  - Internal `start_q` = 0 and wait counter = 0.
- Launch detection:
  - `start_q` registers `start` every cycle.
  - Launch condition is `start` & ~`start_q`, sampled in IDLE or DONE only.
  - A `start` held high does not relaunch.
  - Because `start_q` resets to 0, a `start` already high when reset releases is a launch.
- Legal byte: 8'h20, or 8'h61 <= byte <= 8'h7A. Every other value (including 8'h00, 8'h41–8'h5A, 8'h7B–8'hFF) is illegal.
- States:
  - IDLE: `busy`=0. On launch: `address`<=0, counter<=RD_LAT-1, `done`<=0, `pass`<=0, `fail_index`<=0, `bad_count`<=0, `busy`<=1, go to WAIT.
  - WAIT: hold `address`. When counter==0 go to CHECK; otherwise decrement the counter.
  - CHECK: evaluate `q_ram` in this cycle.
    - Byte illegal (no macro): `fail_index`<=`address`, `bad_count`<=1, `pass`<=0, go to DONE.
    - Last byte legal (`address`==MSG_LEN-1): `pass`<=1, go to DONE.
    - Otherwise: `address`<=`address`+1, counter<=RD_LAT-1, go to WAIT.
  - DONE: `done`=1, `busy`=0; `pass`, `fail_index`, `bad_count` and `address` hold. A launch behaves exactly as from IDLE.
- Timing:
  - Each byte takes RD_LAT+1 cycles.
  - On a pass, `done` rises MSG_LEN*(RD_LAT+1)+1 clock edges after the launch-sampling edge (97 for the defaults).
  - On an early fail at index k, `done` rises (k+1)*(RD_LAT+1)+1 edges after the launch-sampling edge.
- Address arithmetic: `address` never exceeds MSG_LEN-1 and never wraps. With MSG_LEN=2^ADDR_W, the terminal test uses the equality compare, not overflow.
- Reset mid-check aborts immediately to the reset values. No partial result is retained.
- Write port: the block never writes the RAM. The top level muxes `address` onto the RAM port only while `busy`=1.

Optional Feature:
- Macro: `MSG_CHECK_FULL_SCAN_EN`.
- Defined:
  - CHECK never exits early on an illegal byte.
  - Every illegal byte increments `bad_count` (saturating at MSG_LEN).
  - `fail_index` captures only the first illegal address.
  - The scan always covers all MSG_LEN bytes.
  - `pass` = (`bad_count`==0) at DONE.
  - Latency is always MSG_LEN*(RD_LAT+1)+1.
- Undefined: early exit as described under Behaviour. `bad_count` is 0 on pass and 1 on fail.

Test Plan:
- All 32 bytes 8'h61 ("a"), pulse `start` 0->1 -> `busy` for 96 cycles, `done`=1 at edge 97, `pass`=1, `fail_index`=0, `address` stops at 31.
- Byte 5 = 8'h41 ("A"), rest legal (no macro) -> `done` at edge 19, `pass`=0, `fail_index`=5, `bad_count`=1, addresses 6..31 never driven.
- Same memory with `MSG_CHECK_FULL_SCAN_EN`, plus bytes 9 and 31 = 8'h7B -> `done` at edge 97, `pass`=0, `fail_index`=5, `bad_count`=3.
- Boundary bytes 8'h20, 8'h61, 8'h7A are all legal -> `pass`=1. Any single byte of 8'h1F, 8'h60 or 8'h7B -> `pass`=0.
- `start` held high after `done` for 200 cycles -> no relaunch, outputs stable. Then `start` low one cycle and high again -> new check, `done` falls one edge after launch.
- `reset` asserted at cycle 40 of a check -> all outputs 0 asynchronously. Release with `start` high -> a fresh check launches from address 0.
